countdown_display_ctrl: RTL

Sequencer for the traffic-light countdown display. Loads a phase duration in seconds, counts it down on a prescaled one-second tick, and drives the tens/ones 4-bit codes consumed by the per-digit 7-segment decoders. Codes 0–9 are digits, 10 is 'P', and 15 is blank. Optionally shows a pedestrian 'P' phase after the countdown, and pulses `done` when a phase completes.

---
 rtl/traffic_pkg.sv | 21 ++
 rtl/tick_gen.sv | 46 ++++
 rtl/countdown_display_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// ---------------------------------------------------------------------------
// traffic_pkg
// Shared definitions for the traffic-light countdown display blocks.
//   SEG_CODE_P     : decoder code that renders the pedestrian 'P' glyph
//   SEG_CODE_BLANK : decoder code that turns a digit fully off
//   MAX_SEC        : largest duration the two-digit display can show
//   cd_state_t     : countdown sequencer states
// ---------------------------------------------------------------------------
package traffic_pkg;

    localparam logic [3:0] SEG_CODE_P     = 4'd10;
    localparam logic [3:0] SEG_CODE_BLANK = 4'd15;
    localparam logic [6:0] MAX_SEC        = 7'd99;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        PED
    } cd_state_t;

endpackage

// File: rtl/tick_gen.sv
// ---------------------------------------------------------------------------
// tick_gen
// Prescaler producing a one-cycle tick every TICK_DIV clocks while enabled.
//   TICK_DIV : clock cycles per tick (minimum 2)
//   clk      : system clock
//   rst_n    : asynchronous active-low reset
//   en       : run the prescaler; when low it is held at 0
//   clr      : restart the prescaler from 0 (wins over en)
//   tick     : high on the cycle the prescaler sits at TICK_DIV-1
//   phase_hi : high while the prescaler is in the upper half of its period
// ---------------------------------------------------------------------------
module tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick,
    output logic phase_hi
);

    localparam int             CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] HALF  = CNT_W'(TICK_DIV / 2);

    logic [CNT_W-1:0] cnt;

    // Free-running modulo-TICK_DIV counter, parked at zero when idle so the
    // first tick after enabling is a full period away.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || !en) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick     = en && (cnt == LAST);
    assign phase_hi = (cnt >= HALF);

endmodule

// File: rtl/countdown_display_ctrl.sv
// ---------------------------------------------------------------------------
// countdown_display_ctrl
// Counts a loaded phase duration down once per second and drives the two
// digit codes of the countdown display, optionally followed by a pedestrian
// 'P' phase.
//   TICK_DIV  : clock cycles per one-second tick (minimum 2)
//   PED_SEC   : length of the pedestrian phase in ticks (1-99)
//   clk       : system clock
//   rst_n     : asynchronous active-low reset
//   load      : one-cycle start/restart request
//   seconds   : phase duration, clamped to 99, sampled with load
//   ped_req   : pedestrian request, latched while counting
//   tens_code : tens digit decoder code (0-9, 10='P', 15=blank)
//   ones_code : ones digit decoder code
//   remaining : seconds left in the current phase
//   busy      : high while counting or showing the pedestrian phase
//   done      : one-cycle pulse when a phase completes
// Build option: define COUNTDOWN_BLINK_EN to blank both digits during the
// second half of each of the last three seconds of a countdown.
// ---------------------------------------------------------------------------
module countdown_display_ctrl
    import traffic_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int PED_SEC  = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [6:0] seconds,
    input  logic       ped_req,
    output logic [3:0] tens_code,
    output logic [3:0] ones_code,
    output logic [6:0] remaining,
    output logic       busy,
    output logic       done
);

    localparam logic [6:0] PED_REM = 7'(PED_SEC);

    cd_state_t  state, state_d;
    logic [6:0] remaining_d;
    logic       ped_latched, ped_latched_d;
    logic       done_d;
    logic       ped_pending;
    logic       presc_clr;
    logic       tick;
    logic       phase_hi;
    logic [6:0] clamped;
    logic [7:0] digits;

    // Compare-subtract split of 0..99 into {tens, ones}.
    function automatic logic [7:0] to_digits(input logic [6:0] value);
        logic [6:0] rest;
        logic [3:0] tens;
        rest = value;
        tens = 4'd0;
        for (int i = 0; i < 9; i++) begin
            if (rest >= 7'd10) begin
                rest = rest - 7'd10;
                tens = tens + 4'd1;
            end
        end
        return {tens, rest[3:0]};
    endfunction

    assign clamped = (seconds > MAX_SEC) ? MAX_SEC : seconds;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (state != IDLE),
        .clr      (presc_clr),
        .tick     (tick),
        .phase_hi (phase_hi)
    );

    // State, remaining count, pedestrian latch and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            remaining   <= '0;
            ped_latched <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_d;
            remaining   <= remaining_d;
            ped_latched <= ped_latched_d;
            done        <= done_d;
            busy        <= (state_d != IDLE);
        end
    end

    // Next-state logic. A request arriving on the final tick still counts,
    // so the pending flag merges the latch with the live request.
    always_comb begin
        state_d       = state;
        remaining_d   = remaining;
        ped_latched_d = ped_latched;
        done_d        = 1'b0;
        presc_clr     = 1'b0;
        ped_pending   = ped_latched | ped_req;
        case (state)
            IDLE: begin
                if (load) begin
                    presc_clr = 1'b1;
                    if (clamped != 7'd0) begin
                        state_d     = COUNT;
                        remaining_d = clamped;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            COUNT: begin
                ped_latched_d = ped_pending;
                if (load) begin
                    presc_clr = 1'b1;
                    if (clamped != 7'd0) begin
                        remaining_d = clamped;
                    end else begin
                        state_d       = IDLE;
                        remaining_d   = '0;
                        ped_latched_d = 1'b0;
                        done_d        = 1'b1;
                    end
                end else if (tick) begin
                    if (remaining <= 7'd1) begin
                        if (ped_pending) begin
                            state_d       = PED;
                            remaining_d   = PED_REM;
                            ped_latched_d = 1'b0;
                        end else begin
                            state_d     = IDLE;
                            remaining_d = '0;
                            done_d      = 1'b1;
                        end
                    end else begin
                        remaining_d = remaining - 7'd1;
                    end
                end
            end
            PED: begin
                if (tick) begin
                    if (remaining <= 7'd1) begin
                        state_d     = IDLE;
                        remaining_d = '0;
                        done_d      = 1'b1;
                    end else begin
                        remaining_d = remaining - 7'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Digit code decode with leading-zero suppression on the tens digit.
    always_comb begin
        tens_code = SEG_CODE_BLANK;
        ones_code = SEG_CODE_BLANK;
        digits    = to_digits(remaining);
        case (state)
            COUNT: begin
                ones_code = digits[3:0];
                if (remaining >= 7'd10) begin
                    tens_code = digits[7:4];
                end
`ifdef COUNTDOWN_BLINK_EN
                if ((remaining <= 7'd3) && phase_hi) begin
                    tens_code = SEG_CODE_BLANK;
                    ones_code = SEG_CODE_BLANK;
                end
`endif
            end
            PED: begin
                ones_code = SEG_CODE_P;
            end
            default: begin
            end
        endcase
    end

`ifndef COUNTDOWN_BLINK_EN
    logic unused_phase_hi;
    assign unused_phase_hi = phase_hi;
`endif

endmodule
